// File: rtl/mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_stage : MEM pipeline stage with req/ack data bus and MEM/WB reg.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] op_c_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        reg_we_i,
   input  logic        mtype_i,
   input  logic        mem_rw_i,
   input  logic [1:0]  mem_width_i,
   input  logic [31:0] mem_wr_data_i,
   input  logic        mem_rdtype_i,
   input  logic [31:0] mem_addr_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_be_o,
   input  logic        dbus_ack_i,
   input  logic [31:0] dbus_rdata_i,
   output logic        stall_o,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_waddr_o,
   output logic        wb_we_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int                 c_CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);
   localparam logic [0:0]         c_S_IDLE  = 1'b0;
   localparam logic [0:0]         c_S_WAIT  = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_next_state;
   logic [c_CNT_W-1:0] r_cnt;

   logic        r_h_we;
   logic [31:0] r_h_addr;
   logic [3:0]  r_h_be;
   logic [31:0] r_h_wdata;
   logic [1:0]  r_h_width;
   logic        r_h_rdtype;
   logic [4:0]  r_h_waddr;
   logic        r_h_reg_we;

   logic        w_idle;
   logic        w_misalign;
   logic [3:0]  w_be_in;
   logic [31:0] w_wdata_in;
   logic        w_access;
   logic        w_timeout;
   logic        w_done;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [3:0]  w_sel_be;
   logic [31:0] w_sel_wdata;
   logic [1:0]  w_sel_width;
   logic        w_sel_rdtype;
   logic [4:0]  w_sel_waddr;
   logic        w_sel_reg_we;
   logic [31:0] w_shifted;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   assign w_idle = (r_state == c_S_IDLE);

   always_comb begin
      w_misalign = 1'b0;
      w_be_in    = 4'b1111;
      w_wdata_in = mem_wr_data_i;
      case (mem_width_i)
         2'b00: begin
            w_be_in    = 4'b0001 << mem_addr_i[1:0];
            w_wdata_in = {4{mem_wr_data_i[7:0]}};
         end
         2'b01: begin
            w_misalign = mem_addr_i[0];
            w_be_in    = 4'b0011 << {mem_addr_i[1], 1'b0};
            w_wdata_in = {2{mem_wr_data_i[15:0]}};
         end
         default: w_misalign = (mem_addr_i[1:0] != 2'b00);
      endcase
   end

   // In WAIT the bus and the result path run off the captured access only
   assign w_sel_we     = w_idle ? mem_rw_i     : r_h_we;
   assign w_sel_addr   = w_idle ? mem_addr_i   : r_h_addr;
   assign w_sel_be     = w_idle ? w_be_in      : r_h_be;
   assign w_sel_wdata  = w_idle ? w_wdata_in   : r_h_wdata;
   assign w_sel_width  = w_idle ? mem_width_i  : r_h_width;
   assign w_sel_rdtype = w_idle ? mem_rdtype_i : r_h_rdtype;
   assign w_sel_waddr  = w_idle ? reg_waddr_i  : r_h_waddr;
   assign w_sel_reg_we = w_idle ? reg_we_i     : r_h_reg_we;

   assign w_access  = w_idle ? (mtype_i & ~w_misalign) : 1'b1;
   // An ack in the threshold cycle takes priority over the abort
   assign w_timeout = w_access & ~dbus_ack_i & (r_cnt == c_CNT_MAX);
   assign w_done    = w_access & (dbus_ack_i | w_timeout);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_S_IDLE: if (w_access && !w_done) w_next_state = c_S_WAIT;
         c_S_WAIT: if (w_done)              w_next_state = c_S_IDLE;
         default:                           w_next_state = c_S_IDLE;
      endcase
   end

   // Outputs are gated by rst_n so an asserted reset drops the bus at once
   always_comb begin
      dbus_req_o   = rst_n & w_access;
      stall_o      = rst_n & w_access & ~w_done;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = '0;
      dbus_wdata_o = '0;
      dbus_be_o    = '0;
      if (dbus_req_o) begin
         dbus_we_o    = w_sel_we;
         dbus_addr_o  = {w_sel_addr[31:2], 2'b00};
         dbus_wdata_o = w_sel_wdata;
         dbus_be_o    = w_sel_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_h_we     <= 1'b0;
         r_h_addr   <= '0;
         r_h_be     <= '0;
         r_h_wdata  <= '0;
         r_h_width  <= '0;
         r_h_rdtype <= 1'b0;
         r_h_waddr  <= '0;
         r_h_reg_we <= 1'b0;
      end else begin
         if (w_idle) begin
            r_cnt      <= (w_access && !w_done) ? c_CNT_W'(1) : '0;
            r_h_we     <= mem_rw_i;
            r_h_addr   <= mem_addr_i;
            r_h_be     <= w_be_in;
            r_h_wdata  <= w_wdata_in;
            r_h_width  <= mem_width_i;
            r_h_rdtype <= mem_rdtype_i;
            r_h_waddr  <= reg_waddr_i;
            r_h_reg_we <= reg_we_i;
         end else begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
         end
      end
   end

   assign w_shifted = dbus_rdata_i >> {w_sel_addr[1:0], 3'b000};
   assign w_half    = w_sel_addr[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];

   always_comb begin
      case (w_sel_width)
         2'b00:   w_load_data = {{24{~w_sel_rdtype & w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_load_data = {{16{~w_sel_rdtype & w_half[15]}}, w_half};
         default: w_load_data = dbus_rdata_i;
      endcase
   end

   // MEM/WB register; stall cycles issue a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_data_o  <= '0;
         wb_waddr_o <= '0;
         wb_we_o    <= 1'b0;
         misalign_o <= 1'b0;
         bus_err_o  <= 1'b0;
      end else begin
         misalign_o <= w_idle & mtype_i & w_misalign;
         bus_err_o  <= w_timeout;
         if (w_done) begin
            wb_waddr_o <= w_sel_waddr;
            if (w_timeout || w_sel_we) begin
               wb_data_o <= '0;
               wb_we_o   <= 1'b0;
            end else begin
               wb_data_o <= w_load_data;
               wb_we_o   <= w_sel_reg_we & (w_sel_waddr != 5'd0);
            end
         end else if (w_idle && !mtype_i) begin
            wb_data_o  <= op_c_i;
            wb_waddr_o <= reg_waddr_i;
            wb_we_o    <= reg_we_i & (reg_waddr_i != 5'd0);
         end else if (w_idle && w_misalign) begin
            wb_data_o  <= '0;
            wb_waddr_o <= reg_waddr_i;
            wb_we_o    <= 1'b0;
         end else begin
            wb_we_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_stage : directed vector bench for mem_stage (TIMEOUT = 4).      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_mem_stage;

   localparam int c_TO    = 4;
   localparam int c_NVEC  = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] op_c_i;
   logic [4:0]  reg_waddr_i;
   logic        reg_we_i;
   logic        mtype_i;
   logic        mem_rw_i;
   logic [1:0]  mem_width_i;
   logic [31:0] mem_wr_data_i;
   logic        mem_rdtype_i;
   logic [31:0] mem_addr_i;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [31:0] dbus_wdata_o;
   logic [3:0]  dbus_be_o;
   logic        dbus_ack_i;
   logic [31:0] dbus_rdata_i;
   logic        stall_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_waddr_o;
   logic        wb_we_o;
   logic        misalign_o;
   logic        bus_err_o;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(c_TO)) dut (
      .clk(clk), .rst_n(rst_n), .op_c_i(op_c_i), .reg_waddr_i(reg_waddr_i),
      .reg_we_i(reg_we_i), .mtype_i(mtype_i), .mem_rw_i(mem_rw_i),
      .mem_width_i(mem_width_i), .mem_wr_data_i(mem_wr_data_i),
      .mem_rdtype_i(mem_rdtype_i), .mem_addr_i(mem_addr_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
      .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o), .wb_data_o(wb_data_o),
      .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   typedef struct packed {
      logic [31:0] mtype, rw, width, rdtype, addr, wdata, op_c, waddr, reg_we, ack, rdata;
      logic [31:0] e_req, e_we, e_daddr, e_be, e_dwdata, e_stall, e_wb, e_wa, e_wwe, e_mis;
   } vec_t;

   vec_t vecs [c_NVEC];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      op_c_i = '0; reg_waddr_i = '0; reg_we_i = 1'b0; mtype_i = 1'b0;
      mem_rw_i = 1'b0; mem_width_i = 2'b00; mem_wr_data_i = '0;
      mem_rdtype_i = 1'b0; mem_addr_i = '0; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
   endtask

   task automatic mem_op(input logic rw, input logic [1:0] width, input logic rdtype,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] waddr);
      mtype_i = 1'b1; mem_rw_i = rw; mem_width_i = width; mem_rdtype_i = rdtype;
      mem_addr_i = addr; mem_wr_data_i = wdata; reg_waddr_i = waddr; reg_we_i = 1'b1;
      op_c_i = '0; dbus_ack_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      int reqs;
      //          mtype rw width rdt addr       wdata        op_c          wa rwe ack rdata
      //          req we daddr      be      dwdata        stall wb          wa wwe mis
      vecs[0]  = '{0,0,0,0,32'h0,   32'h0,       32'h12345678, 5, 1, 0, 32'h0,
                   0,0,32'h0,   4'h0,   32'h0,        0, 32'h12345678, 5, 1, 0};
      vecs[1]  = '{1,0,0,0,32'h103, 32'h0,       32'h0,        7, 1, 1, 32'h80123456,
                   1,0,32'h100, 4'b1000,32'h0,        0, 32'hFFFFFF80, 7, 1, 0};
      vecs[2]  = '{1,0,0,1,32'h103, 32'h0,       32'h0,        7, 1, 1, 32'h80123456,
                   1,0,32'h100, 4'b1000,32'h0,        0, 32'h00000080, 7, 1, 0};
      vecs[3]  = '{1,0,1,0,32'h106, 32'h0,       32'h0,        8, 1, 1, 32'h80017FFF,
                   1,0,32'h104, 4'b1100,32'h0,        0, 32'hFFFF8001, 8, 1, 0};
      vecs[4]  = '{1,0,1,1,32'h104, 32'h0,       32'h0,        8, 1, 1, 32'h1234F00D,
                   1,0,32'h104, 4'b0011,32'h0,        0, 32'h0000F00D, 8, 1, 0};
      vecs[5]  = '{1,0,2,0,32'h10C, 32'h0,       32'h0,        9, 1, 1, 32'hDEADBEEF,
                   1,0,32'h10C, 4'hF,   32'h0,        0, 32'hDEADBEEF, 9, 1, 0};
      vecs[6]  = '{1,0,3,0,32'h110, 32'h0,       32'h0,        9, 1, 1, 32'hCAFEF00D,
                   1,0,32'h110, 4'hF,   32'h0,        0, 32'hCAFEF00D, 9, 1, 0};
      vecs[7]  = '{1,1,0,0,32'h201, 32'h000000A5,32'h0,        3, 0, 1, 32'h0,
                   1,1,32'h200, 4'b0010,32'hA5A5A5A5, 0, 32'h0,        3, 0, 0};
      vecs[8]  = '{1,1,2,0,32'h300, 32'h11223344,32'h0,        3, 0, 1, 32'h0,
                   1,1,32'h300, 4'hF,   32'h11223344, 0, 32'h0,        3, 0, 0};
      vecs[9]  = '{1,0,2,0,32'h401, 32'h0,       32'h0,        4, 1, 0, 32'h0,
                   0,0,32'h0,   4'h0,   32'h0,        0, 32'h0,        4, 0, 1};
      vecs[10] = '{1,1,1,0,32'h403, 32'h0000FFFF,32'h0,        4, 1, 1, 32'h0,
                   0,0,32'h0,   4'h0,   32'h0,        0, 32'h0,        4, 0, 1};
      vecs[11] = '{0,0,0,0,32'h0,   32'h0,       32'h0BADF00D, 0, 1, 1, 32'hFFFFFFFF,
                   0,0,32'h0,   4'h0,   32'h0,        0, 32'h0BADF00D, 0, 0, 0};
      vecs[12] = '{1,0,0,0,32'h100, 32'h0,       32'h0,        0, 1, 1, 32'h0000007F,
                   1,0,32'h100, 4'b0001,32'h0,        0, 32'h0000007F, 0, 0, 0};
      vecs[13] = '{1,1,1,0,32'h206, 32'h1234ABCD,32'h0,        2, 1, 1, 32'h0,
                   1,1,32'h204, 4'b1100,32'hABCDABCD, 0, 32'h0,        2, 0, 0};
      vecs[14] = '{1,0,0,0,32'h021, 32'h0,       32'h0,        6, 1, 1, 32'h00009100,
                   1,0,32'h020, 4'b0010,32'h0,        0, 32'hFFFFFF91, 6, 1, 0};

      // Reset state
      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk("rst req",     {31'd0, dbus_req_o}, 0);
      chk("rst stall",   {31'd0, stall_o},    0);
      chk("rst daddr",   dbus_addr_o,         0);
      chk("rst wb_data", wb_data_o,           0);
      chk("rst wb_we",   {31'd0, wb_we_o},    0);
      chk("rst mis",     {31'd0, misalign_o}, 0);
      chk("rst berr",    {31'd0, bus_err_o},  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle vectors
      for (int i = 0; i < c_NVEC; i++) begin
         mtype_i = vecs[i].mtype[0]; mem_rw_i = vecs[i].rw[0];
         mem_width_i = vecs[i].width[1:0]; mem_rdtype_i = vecs[i].rdtype[0];
         mem_addr_i = vecs[i].addr; mem_wr_data_i = vecs[i].wdata;
         op_c_i = vecs[i].op_c; reg_waddr_i = vecs[i].waddr[4:0];
         reg_we_i = vecs[i].reg_we[0]; dbus_ack_i = vecs[i].ack[0];
         dbus_rdata_i = vecs[i].rdata;
         #1;
         chk($sformatf("v%0d req", i),    {31'd0, dbus_req_o}, vecs[i].e_req);
         chk($sformatf("v%0d we", i),     {31'd0, dbus_we_o},  vecs[i].e_we);
         chk($sformatf("v%0d daddr", i),  dbus_addr_o,         vecs[i].e_daddr);
         chk($sformatf("v%0d be", i),     {28'd0, dbus_be_o},  vecs[i].e_be);
         chk($sformatf("v%0d dwdata", i), dbus_wdata_o,        vecs[i].e_dwdata);
         chk($sformatf("v%0d stall", i),  {31'd0, stall_o},    vecs[i].e_stall);
         @(posedge clk); #1;
         if (vecs[i].e_mis == 0)
            chk($sformatf("v%0d wb_data", i), wb_data_o, vecs[i].e_wb);
         chk($sformatf("v%0d wb_waddr", i), {27'd0, wb_waddr_o}, vecs[i].e_wa);
         chk($sformatf("v%0d wb_we", i),    {31'd0, wb_we_o},    vecs[i].e_wwe);
         chk($sformatf("v%0d mis", i),      {31'd0, misalign_o}, vecs[i].e_mis);
         chk($sformatf("v%0d berr", i),     {31'd0, bus_err_o},  0);
         @(negedge clk);
      end
      idle_inputs();
      #1;
      chk("mis pulse end", {31'd0, misalign_o}, 0);

      // Halfword store, ack three cycles after request; inputs scrambled in WAIT
      @(negedge clk);
      mem_op(1'b1, 2'b01, 1'b0, 32'h202, 32'hAAAABEEF, 5'd6);
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
         dbus_ack_i = (c == 3);
         if (c >= 1) begin
            mtype_i = 1'b0; mem_addr_i = 32'h999; mem_width_i = 2'b10;
            mem_wr_data_i = 32'h0; mem_rw_i = 1'b0;
         end
         #1;
         chk($sformatf("hs c%0d req", c),    {31'd0, dbus_req_o}, 1);
         chk($sformatf("hs c%0d we", c),     {31'd0, dbus_we_o},  1);
         chk($sformatf("hs c%0d daddr", c),  dbus_addr_o,         32'h200);
         chk($sformatf("hs c%0d be", c),     {28'd0, dbus_be_o},  32'hC);
         chk($sformatf("hs c%0d dwdata", c), dbus_wdata_o,        32'hBEEFBEEF);
         if (stall_o) stalls++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("hs stall cycles", stalls, 3);
      chk("hs wb_we",   {31'd0, wb_we_o},   0);
      chk("hs wb_data", wb_data_o,          0);
      chk("hs berr",    {31'd0, bus_err_o}, 0);
      idle_inputs();

      // Byte load with one wait cycle: offset must come from the captured address
      @(negedge clk);
      mem_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd10);
      #1;
      chk("bl stall0", {31'd0, stall_o},   1);
      chk("bl be",     {28'd0, dbus_be_o}, 32'h2);
      @(negedge clk);
      mem_addr_i = 32'h2; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h0000FF00;
      #1;
      chk("bl stall1", {31'd0, stall_o},   0);
      chk("bl be wait",{28'd0, dbus_be_o}, 32'h2);
      @(posedge clk); #1;
      chk("bl wb_data",  wb_data_o,           32'hFFFFFFFF);
      chk("bl wb_waddr", {27'd0, wb_waddr_o}, 10);
      chk("bl wb_we",    {31'd0, wb_we_o},    1);
      @(negedge clk);
      idle_inputs();

      // Timeout: no ack ever
      @(negedge clk);
      mem_op(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 5'd11);
      reqs = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (!dbus_req_o) break;
         reqs++;
         chk($sformatf("to c%0d stall", c), {31'd0, stall_o}, (c < c_TO - 1) ? 1 : 0);
         @(posedge clk); #1;
         chk($sformatf("to c%0d berr", c), {31'd0, bus_err_o}, (c == c_TO - 1) ? 1 : 0);
         if (c == c_TO - 1) begin
            chk("to wb_we", {31'd0, wb_we_o}, 0);
            @(negedge clk);
            idle_inputs();
            op_c_i = 32'h13572468; reg_waddr_i = 5'd13; reg_we_i = 1'b1;
            #1;
            chk("to req drop", {31'd0, dbus_req_o}, 0);
            break;
         end
         @(negedge clk);
      end
      chk("to req cycles", reqs, c_TO);
      chk("to stall post", {31'd0, stall_o}, 0);
      @(posedge clk); #1;
      chk("to berr end",   {31'd0, bus_err_o}, 0);
      chk("to alu data",   wb_data_o,          32'h13572468);
      chk("to alu we",     {31'd0, wb_we_o},   1);
      @(negedge clk);

      // Reset during WAIT
      mem_op(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 5'd14);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rw req pre", {31'd0, dbus_req_o}, 1);
      rst_n = 1'b0;
      dbus_ack_i = 1'b1;
      #1;
      chk("rw req",     {31'd0, dbus_req_o}, 0);
      chk("rw stall",   {31'd0, stall_o},    0);
      chk("rw daddr",   dbus_addr_o,         0);
      chk("rw wb_data", wb_data_o,           0);
      chk("rw wb_we",   {31'd0, wb_we_o},    0);
      @(posedge clk); #1;
      chk("rw late ack", {31'd0, wb_we_o},   0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      op_c_i = 32'h55AA55AA; reg_waddr_i = 5'd12; reg_we_i = 1'b1;
      #1;
      chk("rw alu req", {31'd0, dbus_req_o}, 0);
      @(posedge clk); #1;
      chk("rw alu data",  wb_data_o,           32'h55AA55AA);
      chk("rw alu waddr", {27'd0, wb_waddr_o}, 12);
      chk("rw alu we",    {31'd0, wb_we_o},    1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs and performs data-memory access over a req/ack data bus.
- Generates byte enables and store-data lane steering; aligns and sign/zero-extends load data.
- Stalls upstream while an access is outstanding.
- Registers results for write-back, so the MEM/WB pipeline register is internal to this block.

Parameters:
- TIMEOUT, 16, max cycles to wait for dbus_ack_i before aborting the access (must be >=1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- op_c_i  input  32  ALU result for non-memory instructions
- reg_waddr_i  input  5  destination register
- reg_we_i  input  1  register write enable
- mtype_i  input  1  1 = memory instruction
- mem_rw_i  input  1  0 = load, 1 = store
- mem_width_i  input  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word
- mem_wr_data_i  input  32  store data, LSB-justified
- mem_rdtype_i  input  1  0 = sign-extend, 1 = zero-extend
- mem_addr_i  input  32  byte address
- dbus_req_o  output  1  bus request
- dbus_we_o  output  1  bus write
- dbus_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- dbus_wdata_o  output  32  lane-steered store data
- dbus_be_o  output  4  byte enables
- dbus_ack_i  input  1  access complete; rdata valid in the same cycle
- dbus_rdata_i  input  32  read word
- stall_o  output  1  hold IF..EX/MEM stages
- wb_data_o  output  32  registered write-back data
- wb_waddr_o  output  5  registered destination
- wb_we_o  output  1  registered write enable
- misalign_o  output  1  one-cycle pulse on a misaligned access
- bus_err_o  output  1  one-cycle pulse on a timeout

Behaviour:
- Reset: FSM=IDLE, timeout counter=0.
- Reset values: wb_data_o=0, wb_waddr_o=0, wb_we_o=0, misalign_o=0, bus_err_o=0.
- Reset values: dbus_req_o=0, stall_o=0; dbus_* data outputs=0.
- Reset mid-access drops dbus_req_o immediately (asynchronous). Any late ack is ignored.
- FSM has two states: IDLE and WAIT.
- Non-memory instruction (mtype_i=0) in IDLE:
  - next edge: wb_data_o<=op_c_i, wb_waddr_o<=reg_waddr_i, wb_we_o<=reg_we_i.
  - latency 1, no stall.
- Misalignment rule: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request.
  - misalign_o pulses on the next edge together with wb_we_o=0.
  - No stall; the FSM stays in IDLE.
- Aligned memory op in IDLE:
  - dbus_req_o=1 combinationally in the same cycle.
  - dbus_we_o=mem_rw_i; dbus_addr_o and data are driven from the inputs.
- Byte enables:
  - byte: be = 0001 << addr[1:0].
  - half: be = 0011 << {addr[1],1'b0}.
  - word: be = 1111.
  - Store data is replicated per width: byte {4{d[7:0]}}, half {2{d[15:0]}}.
- Ack in the same cycle as request in IDLE:
  - no stall; result is registered on that edge.
  - latency 1, identical to a non-memory instruction.
- No ack:
  - stall_o=1 combinationally; FSM -> WAIT.
  - The access is captured into internal holding regs: we, addr, be, wdata, width, rdtype, waddr, reg_we.
  - The bus outputs are driven from the holding regs while in WAIT.
  - Inputs are ignored in WAIT; upstream is frozen by stall_o anyway.
- WAIT:
  - dbus_req_o=1 and stall_o=1 until the ack cycle.
  - In the ack cycle stall_o=0 combinationally; result is registered on that edge; FSM -> IDLE.
  - The next instruction is presented in the following cycle.
- Load result:
  - Byte or half is selected by addr[1:0] from dbus_rdata_i.
  - The selected byte/half is extended per rdtype.
  - wb_data_o<=extended value; wb_we_o<=captured reg_we.
- Store result: wb_we_o<=0; wb_data_o<=0.
- Timeout:
  - The counter increments each WAIT cycle without ack.
  - When it reaches TIMEOUT-1 without ack: drop req, bus_err_o pulse, wb_we_o=0, stall_o=0 that cycle, FSM -> IDLE, counter cleared.
- An ack on the same cycle as the timeout threshold wins; it is a normal completion.
- dbus_ack_i in IDLE with no request is ignored.
- wb_we_o is forced 0 whenever wb_waddr_o would be 0.

Test Plan:
- ALU op: mtype=0, op_c=0x1234_5678, waddr=5, we=1 -> next cycle wb_data=0x12345678, wb_waddr=5, wb_we=1, no req.
- Signed byte load: addr=0x103, width=00, rdtype=0, ack same cycle, rdata=0x80xx_xxxx -> be=1000, wb_data=0xFFFF_FF80, stall never asserted. Repeat with rdtype=1 -> 0x0000_0080.
- Halfword store with 3-cycle ack delay: addr=0x202, data=0xAAAA_BEEF -> dbus_addr=0x200, be=1100, wdata=0xBEEF_BEEF, stall_o high 3 cycles, then wb_we=0.
- Misaligned word: addr=0x401, width=10 -> no dbus_req, misalign_o pulse 1 cycle, wb_we=0.
- Timeout: TIMEOUT=4, never ack -> req high 4 cycles then drops, bus_err_o pulse, stall released, FSM IDLE.
- Reset mid-WAIT: assert rst_n=0 during WAIT -> req, stall and wb_* all 0 immediately; after release, the next ALU op completes normally.
